// File: rtl/lap_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lap_timer_pkg
// Description : Shared types, segment constants and parameter derivations
//               for the lap_timer stopwatch core.
// Revision    : 1.0 - initial release
// ============================================================================
package lap_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Active-low segments {g,f,e,d,c,b,a}
    localparam logic [6:0] c_seg_0     = 7'b1000000;
    localparam logic [6:0] c_seg_1     = 7'b1111001;
    localparam logic [6:0] c_seg_2     = 7'b0100100;
    localparam logic [6:0] c_seg_3     = 7'b0110000;
    localparam logic [6:0] c_seg_4     = 7'b0011001;
    localparam logic [6:0] c_seg_5     = 7'b0010010;
    localparam logic [6:0] c_seg_6     = 7'b0000010;
    localparam logic [6:0] c_seg_7     = 7'b1111000;
    localparam logic [6:0] c_seg_8     = 7'b0000000;
    localparam logic [6:0] c_seg_9     = 7'b0010000;
    localparam logic [6:0] c_seg_blank = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_encode = c_seg_0;
            4'd1:    seg_encode = c_seg_1;
            4'd2:    seg_encode = c_seg_2;
            4'd3:    seg_encode = c_seg_3;
            4'd4:    seg_encode = c_seg_4;
            4'd5:    seg_encode = c_seg_5;
            4'd6:    seg_encode = c_seg_6;
            4'd7:    seg_encode = c_seg_7;
            4'd8:    seg_encode = c_seg_8;
            4'd9:    seg_encode = c_seg_9;
            default: seg_encode = c_seg_blank;
        endcase
    endfunction

    // Tens-of-seconds and tens-of-minutes digits roll over at 6
    function automatic logic [3:0] digit_max(input int idx);
        return (((idx % 2) == 1) && (idx >= 3)) ? 4'd5 : 4'd9;
    endfunction

    function automatic int calc_debounce_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchroniser, stable-count debouncer and one-cycle
//               press pulse for an active-low push button.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic             r_press;
    logic             r_armed;
    logic [1:0]       r_vld;
    logic [CNT_W-1:0] r_cnt;

    // A press is only reported once the key has been seen released after
    // reset, so a button held through reset never fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_press    <= 1'b0;
            r_armed    <= 1'b0;
            r_vld      <= 2'b00;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= key_n;
            r_sync2    <= r_sync1;
            r_vld      <= {r_vld[0], 1'b1};
            r_armed    <= r_armed | (r_vld[1] & r_sync2);
            r_stable_d <= r_stable;
            r_press    <= r_armed & r_stable_d & ~r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/lap_timer.sv
`default_nettype none
// ============================================================================
// Module      : lap_timer
// Description : BCD stopwatch / countdown core (mm:ss.cc) with debounced
//               keys, lap-hold display and seven-segment outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module lap_timer
    import lap_timer_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int NUM_DIGITS  = 6,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic                    KEY_START_N,
    input  logic                    KEY_LAP_N,
    input  logic                    SW_DOWN,
    input  logic [4*NUM_DIGITS-1:0] PRESET,
    output logic [7*NUM_DIGITS-1:0] HEX_N,
    output logic [NUM_DIGITS-1:0]   DP_N,
    output logic [4*NUM_DIGITS-1:0] COUNT_BCD,
    output logic [3:0]              STATUS
);

    localparam int DEBOUNCE_CYCLES = calc_debounce_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int DIV             = calc_div(CLK_HZ, TICK_HZ);
    localparam int DIV_W           = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCD_W           = 4 * NUM_DIGITS;

    state_t             r_state;
    logic [BCD_W-1:0]   r_count;
    logic [BCD_W-1:0]   r_lap_reg;
    logic               r_lap_hold;
    logic               r_done;
    logic               r_mode_down;
    logic               r_sw_sync1;
    logic               r_sw_sync2;
    logic [DIV_W-1:0]   r_presc;
    logic [7*NUM_DIGITS-1:0] r_hex_n;
    logic [3:0]         r_status;

    logic               w_start;
    logic               w_lap;
    logic               w_tick;
    logic [BCD_W-1:0]   w_count_inc;
    logic [BCD_W-1:0]   w_count_dec;
    logic [BCD_W-1:0]   w_preset_clamped;
    logic [BCD_W-1:0]   w_disp;
    logic [7*NUM_DIGITS-1:0] w_hex_n;
    logic [NUM_DIGITS-1:0]   w_dp_n;
    logic               w_carry;
    logic               w_borrow;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .key_n (KEY_START_N),
        .press (w_start)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_lap (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .key_n (KEY_LAP_N),
        .press (w_lap)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sw_sync1 <= 1'b0;
            r_sw_sync2 <= 1'b0;
        end else begin
            r_sw_sync1 <= SW_DOWN;
            r_sw_sync2 <= r_sw_sync1;
        end
    end

    assign w_tick = (r_state == ST_RUNNING) && (r_presc == DIV_W'(DIV - 1));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_presc <= '0;
        end else if (r_state != ST_RUNNING || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Ripple carry/borrow across digits, each with its own modulus
    always_comb begin
        w_count_inc      = r_count;
        w_count_dec      = r_count;
        w_preset_clamped = PRESET;
        w_carry          = 1'b1;
        w_borrow         = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] >= digit_max(i)) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_count_dec[4*i +: 4] = digit_max(i);
                end else begin
                    w_count_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    w_borrow = 1'b0;
                end
            end
            if (PRESET[4*i +: 4] > digit_max(i)) begin
                w_preset_clamped[4*i +: 4] = digit_max(i);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_lap_reg   <= '0;
            r_lap_hold  <= 1'b0;
            r_done      <= 1'b0;
            r_mode_down <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mode_down <= r_sw_sync2;
                    if (w_start) begin
                        if (r_mode_down && (r_count == '0)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUNNING;
                        end
                    end else if (w_lap) begin
                        r_count <= r_mode_down ? w_preset_clamped : '0;
                    end
                end
                ST_RUNNING: begin
                    if (w_start) begin
                        r_state    <= ST_IDLE;
                        r_lap_hold <= 1'b0;
                    end else begin
                        if (w_lap) begin
                            r_lap_hold <= ~r_lap_hold;
                            if (!r_lap_hold) begin
                                r_lap_reg <= r_count;
                            end
                        end
                        if (w_tick) begin
                            if (r_mode_down) begin
                                r_count <= w_count_dec;
                                if (w_count_dec == '0) begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_count <= w_count_inc;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_count <= '0;
                    if (w_start || w_lap) begin
                        r_count <= w_preset_clamped;
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_disp = r_lap_hold ? r_lap_reg : r_count;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_hex_n[7*gi +: 7] = seg_encode(w_disp[4*gi +: 4]);
        assign w_dp_n[gi]         = !((gi == 2) || (gi == 4));
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hex_n  <= {NUM_DIGITS{c_seg_0}};
            r_status <= 4'b0000;
        end else begin
            r_hex_n  <= w_hex_n;
            r_status <= {r_mode_down, r_done, r_lap_hold, (r_state == ST_RUNNING)};
        end
    end

    assign HEX_N     = r_hex_n;
    assign DP_N      = w_dp_n;
    assign COUNT_BCD = r_count;
    assign STATUS    = r_status;

endmodule
`default_nettype wire

// File: tb/tb_lap_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lap_timer
// Description : Directed self-checking bench for lap_timer (DIV=10, 4-cycle
//               debounce, 6 digits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lap_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_start_n;
    logic        key_lap_n;
    logic        sw_down;
    logic [23:0] preset;
    logic [41:0] hex_n;
    logic [5:0]  dp_n;
    logic [23:0] count_bcd;
    logic [3:0]  status;

    int n_checks = 0;
    int n_fail   = 0;

    lap_timer #(
        .CLK_HZ      (1000),
        .TICK_HZ     (100),
        .NUM_DIGITS  (6),
        .DEBOUNCE_MS (4)
    ) u_dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .KEY_START_N (key_start_n),
        .KEY_LAP_N   (key_lap_n),
        .SW_DOWN     (sw_down),
        .PRESET      (preset),
        .HEX_N       (hex_n),
        .DP_N        (dp_n),
        .COUNT_BCD   (count_bcd),
        .STATUS      (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] exp_hex(input logic [23:0] bcd);
        logic [41:0] h;
        for (int i = 0; i < 6; i++) h[7*i +: 7] = seg(bcd[4*i +: 4]);
        return h;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        key_start_n = 1'b0;
        cycles(10);
        key_start_n = 1'b1;
        cycles(10);
    endtask

    task automatic press_lap();
        key_lap_n = 1'b0;
        cycles(10);
        key_lap_n = 1'b1;
        cycles(10);
    endtask

    task automatic wait_running(input int limit);
        for (int k = 0; k < limit && status[0] !== 1'b1; k++) cycles(1);
    endtask

    task automatic wait_count_ne(input logic [23:0] v, input int limit);
        for (int k = 0; k < limit && count_bcd === v; k++) cycles(1);
    endtask

    task automatic wait_count_eq(input logic [23:0] v, input int limit);
        for (int k = 0; k < limit && count_bcd !== v; k++) cycles(1);
    endtask

    initial begin
        rst_n       = 1'b0;
        key_start_n = 1'b0;
        key_lap_n   = 1'b1;
        sw_down     = 1'b0;
        preset      = 24'h000000;
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        check("rst_hex",    hex_n,     exp_hex(24'h000000));
        check("rst_dp",     dp_n,      6'b101011);
        check("rst_status", status,    4'b0000);
        check("rst_count",  count_bcd, 24'h000000);
        cycles(20);
        check("held_no_start", status, 4'b0000);
        key_start_n = 1'b1;
        cycles(20);
        check("release_no_start", status, 4'b0000);

        key_start_n = 1'b0;
        cycles(2);
        key_start_n = 1'b1;
        cycles(20);
        check("glitch_ignored", status, 4'b0000);

        // Count up for one second
        key_start_n = 1'b0;
        wait_running(30);
        check("start_run", status, 4'b0001);
        key_start_n = 1'b1;
        wait_count_ne(24'h000000, 40);
        check("first_tick", count_bcd, 24'h000001);
        cycles(990);
        check("one_second", count_bcd, 24'h000100);
        press_start();
        check("stop_idle", status, 4'b0000);
        check("stop_hold", count_bcd, 24'h000100);

        // Lap hold
        press_lap();
        check("clear_up", count_bcd, 24'h000000);
        press_start();
        wait_count_eq(24'h000049, 600);
        cycles(5);
        key_lap_n = 1'b0;
        cycles(10);
        key_lap_n = 1'b1;
        cycles(25);
        check("lap_count_live", count_bcd, 24'h000053);
        check("lap_hex_held",   hex_n,     exp_hex(24'h000050));
        check("lap_status",     status,    4'b0011);
        press_lap();
        check("lap_off_status", status, 4'b0001);
        wait_count_eq(24'h000060, 200);
        cycles(2);
        check("live_hex", hex_n, exp_hex(24'h000060));
        press_lap();
        check("lap_again", status, 4'b0011);
        press_start();
        check("stop_clears_lap", status, 4'b0000);

        // Up-count wrap from the maximum value
        sw_down = 1'b1;
        preset  = 24'h595999;
        cycles(5);
        press_lap();
        check("preload_max", count_bcd, 24'h595999);
        check("mode_down",   status,    4'b1000);
        sw_down = 1'b0;
        cycles(5);
        check("mode_up", status, 4'b0000);
        key_start_n = 1'b0;
        cycles(10);
        key_start_n = 1'b1;
        wait_count_ne(24'h595999, 40);
        check("wrap", count_bcd, 24'h000000);
        cycles(2);
        check("wrap_running", status, 4'b0001);
        press_start();

        // Count down to done
        sw_down = 1'b1;
        preset  = 24'h000003;
        cycles(5);
        press_lap();
        check("down_load", count_bcd, 24'h000003);
        key_start_n = 1'b0;
        cycles(10);
        key_start_n = 1'b1;
        wait_count_ne(24'h000003, 40);
        check("down_2", count_bcd, 24'h000002);
        cycles(10);
        check("down_1", count_bcd, 24'h000001);
        cycles(10);
        check("down_0", count_bcd, 24'h000000);
        cycles(2);
        check("done_status", status, 4'b1100);
        press_lap();
        check("done_reload", count_bcd, 24'h000003);
        check("done_idle",   status,    4'b1000);

        // Preset clamping and simultaneous keys
        preset = 24'h009000;
        press_lap();
        check("clamp", count_bcd, 24'h005000);
        key_start_n = 1'b0;
        key_lap_n   = 1'b0;
        wait_running(30);
        check("both_count",  count_bcd, 24'h005000);
        check("both_status", status,    4'b1001);
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        cycles(20);

        rst_n = 1'b0;
        #1;
        check("async_rst_status", status,    4'b0000);
        check("async_rst_count",  count_bcd, 24'h000000);
        check("async_rst_hex",    hex_n,     exp_hex(24'h000000));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
